// File: rtl/hamming_pkg.sv
// Shared types and sizing helpers for the SECDED Hamming decoder.
// Codeword layout: Hamming positions in bits 0..CW_W-2, overall parity on top.
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN,
        SEC,
        DED
    } cls_t;

    function automatic int parity_bits(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) begin
            p++;
        end
        return p;
    endfunction

    function automatic int cw_width(input int data_w);
        return data_w + parity_bits(data_w) + 1;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome, overall parity, classification and correction
// for one SECDED codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    localparam int P = parity_bits(DATA_W),
    localparam int CW_W = cw_width(DATA_W)
) (
    input  logic [CW_W-1:0]   cw,
    output logic [P-1:0]      syn,
    output logic              q,
    output logic [DATA_W-1:0] data,
    output cls_t              cls
);

    logic [CW_W-1:0] fixed;
    logic            flip;
    int              k;

    always_comb begin
        syn = '0;
        for (int i = 0; i < CW_W - 1; i++) begin
            if (cw[i]) begin
                syn = syn ^ P'(i + 1);
            end
        end
        q = ^cw;

        cls  = CLEAN;
        flip = 1'b0;
        if (syn == '0) begin
            cls = q ? SEC : CLEAN;
        end else if (q && (int'(syn) <= CW_W - 1)) begin
            cls  = SEC;
            flip = 1'b1;
        end else begin
            // even-weight error, or a syndrome pointing past the codeword
            cls = DED;
        end

        fixed = cw;
        for (int i = 0; i < CW_W - 1; i++) begin
            if (flip && (syn == P'(i + 1))) begin
                fixed[i] = ~fixed[i];
            end
        end

        // data bits sit on the non-power-of-two positions, ascending
        data = '0;
        k    = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data[k] = fixed[pos-1];
                k++;
            end
        end
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// SECDED decoder with a one-entry registered output stage and a
// valid/ready handshake; error counters built in with HAMMING_ERR_CNT_EN.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W = 16,
    localparam int P = parity_bits(DATA_W),
    localparam int CW_W = cw_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   in_cw,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    logic [P-1:0]      syn;
    logic              q;
    logic [DATA_W-1:0] fix_data;
    cls_t              cls;
    logic              accept;

    hamming_syndrome #(
        .DATA_W(DATA_W)
    ) u_syn (
        .cw  (in_cw),
        .syn (syn),
        .q   (q),
        .data(fix_data),
        .cls (cls)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= fix_data;
            out_sec   <= (cls == SEC);
            out_ded   <= (cls == DED);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (accept) begin
            if ((cls == SEC) && (sec_cnt != '1)) begin
                sec_cnt <= sec_cnt + CNT_W'(1);
            end
            if ((cls == DED) && (ded_cnt != '1)) begin
                ded_cnt <= ded_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign sec_cnt = '0;
    assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder (DATA_W=4, CW_W=8),
// directed codewords with hand-computed results.
module tb_hamming_secded_decoder;

    localparam int DATA_W = 4;
    localparam int CNT_W = 16;
    localparam int CW_W = 8;
`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [CW_W-1:0]   in_cw;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sec;
    logic              out_ded;
    logic              out_valid;
    logic              out_ready;
    logic              cnt_clr;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;

    typedef struct packed {
        logic [3:0] data;
        logic       sec;
        logic       ded;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   compared = 0;
    int   mismatched = 0;
    int   esc = 0;
    int   edc = 0;

    hamming_secded_decoder #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_cw    (in_cw),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sec  (out_sec),
        .out_ded  (out_ded),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cnt_clr  (cnt_clr),
        .sec_cnt  (sec_cnt),
        .ded_cnt  (ded_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds the word on the input until accepted; returns 1ns after that edge.
    task automatic send(input logic [7:0] cw, input logic [3:0] d,
                        input logic s, input logic e);
        bit done;
        exp_t x;
        done     = 1'b0;
        in_cw    = cw;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (in_ready) begin
                x = '{data: d, sec: s, ded: e};
                sb.push_back(x);
                if (CNT_ON) begin
                    esc += int'(s);
                    edc += int'(e);
                end
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                mx = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(mx.data));
                chk("out_sec", 32'(out_sec), 32'(mx.sec));
                chk("out_ded", 32'(out_ded), 32'(mx.ded));
                chk("sec_ded_excl", 32'(out_sec & out_ded), 32'd0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_cw     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sec", 32'(out_sec), 32'd0);
        chk("rst_ded", 32'(out_ded), 32'd0);
        chk("rst_sec_cnt", 32'(sec_cnt), 32'd0);
        chk("rst_ded_cnt", 32'(ded_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;

        send(8'h55, 4'hB, 1'b0, 1'b0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        send(8'h51, 4'hB, 1'b1, 1'b0);
        chk("sec_cnt_1", 32'(sec_cnt), 32'(esc));
        send(8'hD5, 4'hB, 1'b1, 1'b0);
        send(8'h56, 4'hB, 1'b0, 1'b1);
        chk("ded_cnt_1", 32'(ded_cnt), 32'(edc));
        send(8'h00, 4'h0, 1'b0, 1'b0);
        send(8'hFF, 4'hF, 1'b0, 1'b0);
        send(8'hBF, 4'hF, 1'b1, 1'b0);
        send(8'h7E, 4'hF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("drained", 32'(out_valid), 32'd0);

        // backpressure with a pending word on the input
        out_ready = 1'b0;
        send(8'hBF, 4'hF, 1'b1, 1'b0);
        in_cw    = 8'h55;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'hF);
            chk("bp_hold_sec", 32'(out_sec), 32'd1);
        end
        out_ready = 1'b1;
        send(8'h55, 4'hB, 1'b0, 1'b0);
        send(8'hD5, 4'hB, 1'b1, 1'b0);
        send(8'h56, 4'hB, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // clear wins over a simultaneous sec increment
        cnt_clr = 1'b1;
        send(8'h51, 4'hB, 1'b1, 1'b0);
        cnt_clr = 1'b0;
        esc = 0;
        edc = 0;
        chk("clr_sec_cnt", 32'(sec_cnt), 32'd0);
        chk("clr_ded_cnt", 32'(ded_cnt), 32'd0);
        send(8'h56, 4'hB, 1'b0, 1'b1);
        chk("ded_after_clr", 32'(ded_cnt), 32'(edc));
        @(posedge clk);
        #1;

        // reset while a word is held and another is offered
        out_ready = 1'b0;
        send(8'hBF, 4'hF, 1'b1, 1'b0);
        chk("sec_before_rst", 32'(sec_cnt), 32'(esc));
        in_cw    = 8'h55;
        in_valid = 1'b1;
        #2 rst = 1'b1;
        esc = 0;
        edc = 0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_sec", 32'(out_sec), 32'd0);
        chk("mid_rst_ded", 32'(out_ded), 32'd0);
        chk("mid_rst_sec_cnt", 32'(sec_cnt), 32'(esc));
        chk("mid_rst_ded_cnt", 32'(ded_cnt), 32'(edc));
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_ghost_out", 32'(out_valid), 32'd0);
        end
        send(8'h51, 4'hB, 1'b1, 1'b0);
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_sec_cnt", 32'(sec_cnt), 32'(esc));
        @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 4, giving the number of data bits per word; legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of each error counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_cw, input, CW_W bits: codeword; CW_W = DATA_W + P + 1, where P is the smallest value with 2^P >= DATA_W + P + 1.
REQ-006 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the input handshake.
REQ-007 SHALL have port out_data, output, DATA_W bits: corrected data.
REQ-008 SHALL have ports out_sec and out_ded, output, 1 bit each: single-error-corrected flag and double-error-detected flag.
REQ-009 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the output handshake.
REQ-010 SHALL have port cnt_clr, input, 1 bit: synchronous clear of both counters.
REQ-011 SHALL have ports sec_cnt and ded_cnt, output, CNT_W bits each: error counters (present only per REQ-026).

Function
REQ-012 SHALL lay out the codeword as follows: bit i holds Hamming position i+1 for i < CW_W-1; powers-of-two positions are parity; the remaining positions carry data bits in ascending order; bit CW_W-1 is overall even parity over bits 0..CW_W-2.
REQ-013 SHALL compute syndrome S as the XOR of (i+1) over every set bit i < CW_W-1, and overall parity Q as the XOR of all CW_W bits.
REQ-014 SHALL classify each word as follows:
- S=0, Q=0: clean; sec=0, ded=0.
- S!=0, Q=1, S <= CW_W-1: flip bit S-1; sec=1.
- S=0, Q=1: overall-parity bit in error; data unchanged; sec=1.
- S!=0, Q=0: ded=1; data passed uncorrected.
REQ-015 SHALL treat S!=0 with Q=1 and S > CW_W-1 as uncorrectable: ded=1, sec=0, data uncorrected.
REQ-016 SHALL never assert out_sec and out_ded together.
REQ-017 SHALL register results in a one-entry output stage, so latency is exactly 1 cycle from the accepting edge to out_valid.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (combinational); an accept occurs when in_valid && in_ready.
REQ-019 SHALL give full throughput: accept and drain in the same cycle loads the new word, and out_valid stays 1.
REQ-020 SHALL hold out_data, out_sec and out_ded stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid after a drain when there is no accept in the same cycle.

Reset
REQ-022 SHALL, while rst=1, force out_valid=0, out_data=0, out_sec=0, out_ded=0, sec_cnt=0 and ded_cnt=0, independent of clk.
REQ-023 SHALL discard any word in flight when reset is asserted mid-operation; no output appears for it after reset.
REQ-024 SHALL resume accepting on the first rising edge after rst falls, with in_ready=1.

Configuration
REQ-025 SHALL use the macro HAMMING_ERR_CNT_EN to compile the counters in or out.
REQ-026 SHALL, when HAMMING_ERR_CNT_EN is defined, increment sec_cnt/ded_cnt by 1 on each accepted word classified sec/ded, saturating at all-ones; cnt_clr wins over a simultaneous increment.
REQ-027 SHALL, when HAMMING_ERR_CNT_EN is undefined, omit the counter registers, tie sec_cnt and ded_cnt to 0, and ignore cnt_clr.

Structure
REQ-028 SHALL place the following in shared package hamming_pkg: function parity_bits(data_w) returning P; function cw_width(data_w); a typedef enum for classification {CLEAN, SEC, DED}.
REQ-029 SHALL contain one combinational sub-module, hamming_syndrome (parameter DATA_W; inputs: codeword; outputs: S, Q, corrected data, classification), instantiated once.

Verification (DATA_W=4, CW_W=8)
REQ-030 SHALL cover: in_cw=8'h55 -> out_data=4'hB, sec=0, ded=0, out_valid one cycle after accept.
REQ-031 SHALL cover: in_cw=8'h51 (bit 2 flipped) -> out_data=4'hB, sec=1; sec_cnt increments to 1 when counters are enabled.
REQ-032 SHALL cover: in_cw=8'hD5 (overall parity bit flipped) -> out_data=4'hB, sec=1, ded=0.
REQ-033 SHALL cover: in_cw=8'h56 (bits 0 and 1 flipped) -> ded=1, sec=0, out_data=4'hB uncorrected; ded_cnt increments to 1.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output held; back-to-back words then drain one per cycle with no loss or duplication.
REQ-035 SHALL cover reset and clear: rst pulsed mid-stream -> all outputs 0 at once; cnt_clr together with a sec word -> sec_cnt=0.
